// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit and receive paths.
//   parity_e        : encoding of the cfg_parity input (3 is reserved = none)
//   state_e         : transmitter frame states
//   UART_IDLE_LEVEL : level of an idle serial line
//   parity_enabled(): true when a cfg_parity code adds a parity bit
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Code 3 is reserved and behaves like PAR_NONE.
    function automatic logic parity_enabled(input logic [1:0] cfg);
        return (cfg == PAR_EVEN) || (cfg == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Loadable bit-time down-counter. On load the count and the reload value are
// both taken from load_value; afterwards the count runs down to 0, raises tick
// for that one cycle, and reloads. One bit time is therefore load_value+1
// cycles, and the all-ones value gives 2^DIV_WIDTH cycles without overflow.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   load        : start a new bit-time sequence (has priority over tick)
//   load_value  : cycles per bit minus 1
//   tick        : high on the cycle the count is 0 (last cycle of a bit)
// -----------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int DIV_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] load_value,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] count;
    logic [DIV_WIDTH-1:0] reload;

    assign tick = (count == '0);

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others, whatever the statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            reload <= '0;
        end else if (load) begin
            count  <= load_value;
            reload <= load_value;
        end else if (tick) begin
            count  <= reload;
        end else begin
            count  <= count - 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
// UART transmitter: accepts one byte per valid/ready transfer and serialises it
// as start, DATA_BITS data (LSB first), optional even/odd parity, then one or
// two stop bits. Configuration is latched together with the data.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   cfg_div     : clk cycles per bit minus 1
//   cfg_parity  : 0 none, 1 even, 2 odd, 3 none
//   cfg_stop2   : 1 selects two stop bits
//   in_valid    : payload available
//   in_data     : payload
//   in_ready    : high only in IDLE (and never during reset)
//   tx          : registered serial line, idle high
//   busy        : high in every state except IDLE
//   frame_done  : pulse in the last cycle of the final stop bit
// The registered tx trails the state by one cycle, so the start bit appears on
// the edge after the transfer edge while the state machine changes on it.
// -----------------------------------------------------------------------------
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int DIV_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_stop2,
    input  logic                 in_valid,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    state_e               state;
    logic [DATA_BITS-1:0] shreg;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 par_acc;
    logic                 par_en;
    logic                 par_odd;
    logic                 stop2;
    logic                 stop_cnt;   // set once the first of two stop bits is done
    logic                 tx_q;
    logic                 tx_next;
    logic                 tick;
    logic                 accept;
    logic                 last_data;
    logic                 last_stop;

    assign in_ready   = (state == S_IDLE) && !reset;
    assign accept     = in_valid && in_ready;
    assign busy       = (state != S_IDLE);
    assign last_data  = (bit_cnt == CNT_W'(DATA_BITS - 1));
    assign last_stop  = !stop2 || stop_cnt;
    assign frame_done = (state == S_STOP) && tick && last_stop;
    assign tx         = tx_q;

    uart_baud_tick #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .load_value (cfg_div),
        .tick       (tick)
    );

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        tx_next = UART_IDLE_LEVEL;
        case (state)
            S_START:  tx_next = 1'b0;
            S_DATA:   tx_next = shreg[0];
            S_PARITY: tx_next = par_acc ^ par_odd;
            default:  tx_next = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: datapath registers are cleared too; they are few and a
            // known value keeps the line and the bench deterministic after reset.
            state    <= S_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            par_acc  <= 1'b0;
            par_en   <= 1'b0;
            par_odd  <= 1'b0;
            stop2    <= 1'b0;
            stop_cnt <= 1'b0;
            tx_q     <= UART_IDLE_LEVEL;
        end else begin
            tx_q <= tx_next;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        shreg    <= in_data;
                        par_en   <= parity_enabled(cfg_parity);
                        par_odd  <= (cfg_parity == PAR_ODD);
                        stop2    <= cfg_stop2;
                        bit_cnt  <= '0;
                        par_acc  <= 1'b0;
                        stop_cnt <= 1'b0;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (tick) state <= S_DATA;
                end
                S_DATA: begin
                    if (tick) begin
                        // Parity is a running XOR of the bits as they leave.
                        par_acc <= par_acc ^ shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= last_data ? '0 : bit_cnt + 1'b1;
                        if (last_data) state <= par_en ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    if (tick) state <= S_STOP;
                end
                S_STOP: begin
                    if (tick) begin
                        if (last_stop) state    <= S_IDLE;
                        else           stop_cnt <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_frame
// Directed bench for uart_tx_frame. Each frame is described by a hand-written
// bit vector (bit i = i-th bit on the line, start bit first). Outputs are
// sampled 1 time unit after each rising edge; edge 0 is the transfer edge, so
// for a frame of len cycles:
//   tx after edge k (1..len)  = frame bit (k-1)/(div+1), then 1 after edge len+1
//   frame_done high only after edge len-1 (the cycle ending on edge len)
//   in_ready first high and busy first low after edge len
// -----------------------------------------------------------------------------
module tb_uart_tx_frame;

    localparam int DATA_BITS = 8;
    localparam int DIV_WIDTH = 12;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [DIV_WIDTH-1:0] cfg_div;
    logic [1:0]           cfg_parity;
    logic                 cfg_stop2;
    logic                 in_valid;
    logic [DATA_BITS-1:0] in_data;
    logic                 in_ready;
    logic                 tx;
    logic                 busy;
    logic                 frame_done;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_frame #(
        .DATA_BITS (DATA_BITS),
        .DIV_WIDTH (DIV_WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_div    (cfg_div),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a frame request and return just after its transfer edge. With
    // hold=0 the request is withdrawn and every input is scrambled, which must
    // not disturb the frame now in flight.
    task automatic start(input logic [7:0] data, input int div,
                         input logic [1:0] par, input logic stop2,
                         input logic hold, input string tag);
        int waited = 0;
        in_data    = data;
        cfg_div    = DIV_WIDTH'(div);
        cfg_parity = par;
        cfg_stop2  = stop2;
        in_valid   = 1'b1;
        while (!in_ready && waited < 50000) begin
            step();
            waited++;
        end
        if (!in_ready) check({tag, " in_ready_timeout"}, 32'(in_ready), 32'd1);
        step();
        if (!hold) begin
            in_valid   = 1'b0;
            in_data    = ~data;
            cfg_div    = cfg_div ^ DIV_WIDTH'(3);
            cfg_parity = ~par;
            cfg_stop2  = ~stop2;
        end
    endtask

    // Follow one frame from the edge after its transfer edge to edge len+1.
    task automatic watch(input logic [11:0] exp_bits, input int nbits,
                         input int div, input string tag);
        int   len     = nbits * (div + 1);
        int   bad_tx  = 0;
        int   fd_at   = -1;
        int   fd_cnt  = 0;
        int   rdy_at  = -1;
        int   idle_at = -1;
        int   idx;
        logic exp_tx;
        for (int k = 1; k <= len + 1; k++) begin
            step();
            idx    = (k - 1) / (div + 1);
            exp_tx = (k <= len) ? exp_bits[idx] : 1'b1;
            if (tx !== exp_tx) bad_tx++;
            if (frame_done === 1'b1) begin
                fd_cnt++;
                if (fd_at < 0) fd_at = k;
            end
            if (k <= len && in_ready === 1'b1 && rdy_at < 0) rdy_at = k;
            if (k <= len && busy !== 1'b1 && idle_at < 0) idle_at = k;
        end
        check({tag, " tx_bad_cycles"},   32'(bad_tx),  32'd0);
        check({tag, " frame_done_edge"}, 32'(fd_at),   32'(len - 1));
        check({tag, " frame_done_count"},32'(fd_cnt),  32'd1);
        check({tag, " in_ready_edge"},   32'(rdy_at),  32'(len));
        check({tag, " busy_low_edge"},   32'(idle_at), 32'(len));
    endtask

    initial begin
        int fd_cnt;
        int tx_low;

        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        cfg_div    = '0;
        cfg_parity = 2'd0;
        cfg_stop2  = 1'b0;

        // Power-on reset.
        repeat (3) step();
        check("por tx",         32'(tx),         32'd1);
        check("por in_ready",   32'(in_ready),   32'd0);
        check("por busy",       32'(busy),       32'd0);
        check("por frame_done", 32'(frame_done), 32'd0);
        reset = 1'b0;
        #1;
        check("por in_ready_after", 32'(in_ready), 32'd1);

        // 8N1 0x55, 4 clk per bit: 0,1,0,1,0,1,0,1,0,1.
        start(8'h55, 3, 2'd0, 1'b0, 1'b0, "8n1_55");
        watch(12'h2AA, 10, 3, "8n1_55");

        // Parity frames at 1 clk per bit.
        start(8'h07, 0, 2'd1, 1'b0, 1'b0, "8e1_07");
        watch(12'h60E, 11, 0, "8e1_07");
        start(8'h07, 0, 2'd2, 1'b0, 1'b0, "8o1_07");
        watch(12'h40E, 11, 0, "8o1_07");
        start(8'h03, 0, 2'd1, 1'b0, 1'b0, "8e1_03");
        watch(12'h406, 11, 0, "8e1_03");
        start(8'h03, 0, 2'd2, 1'b0, 1'b0, "8o1_03");
        watch(12'h606, 11, 0, "8o1_03");

        // Reserved parity code behaves as no parity.
        start(8'h07, 0, 2'd3, 1'b0, 1'b0, "par3_07");
        watch(12'h20E, 10, 0, "par3_07");

        // Two stop bits, 2 clk per bit: low 2, high 20.
        start(8'hFF, 1, 2'd0, 1'b1, 1'b0, "8n2_ff");
        watch(12'h7FE, 11, 1, "8n2_ff");

        // Back-to-back: in_valid stays high; the second request and a new
        // divisor are presented while the first frame is on the line.
        start(8'h01, 2, 2'd0, 1'b0, 1'b1, "b2b_1");
        in_data = 8'h80;
        cfg_div = DIV_WIDTH'(7);
        watch(12'h202, 10, 2, "b2b_1");
        in_valid = 1'b0;
        in_data  = 8'hFF;
        cfg_div  = DIV_WIDTH'(1);
        watch(12'h300, 10, 7, "b2b_2");

        // Reset while a frame is on the line (tx low after edge 10).
        start(8'hA5, 3, 2'd0, 1'b0, 1'b0, "rst_mid");
        repeat (10) step();
        check("rst_mid tx_before", 32'(tx), 32'd0);
        reset = 1'b1;
        step();
        check("rst_mid tx_abort",   32'(tx),       32'd1);
        check("rst_mid in_ready",   32'(in_ready), 32'd0);
        check("rst_mid busy",       32'(busy),     32'd0);
        repeat (2) step();
        reset = 1'b0;
        #1;
        check("rst_mid tx_after",       32'(tx),       32'd1);
        check("rst_mid busy_after",     32'(busy),     32'd0);
        check("rst_mid in_ready_after", 32'(in_ready), 32'd1);
        fd_cnt = 0;
        tx_low = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (frame_done === 1'b1) fd_cnt++;
            if (tx !== 1'b1) tx_low++;
        end
        check("rst_mid no_frame_done", 32'(fd_cnt), 32'd0);
        check("rst_mid line_idle",     32'(tx_low), 32'd0);

        // Largest divisor: 4096 clk per bit, 40960 clk per frame.
        start(8'h00, 4095, 2'd0, 1'b0, 1'b0, "maxdiv");
        watch(12'h200, 10, 4095, "maxdiv");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
